// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding, the bundled
// request fields muxed onto the memory port, and the starvation counter width.
// Latency: n/a (types only). Backpressure: n/a.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ren;
    logic        wen;
    logic [3:0]  byte_en;
  } bus_req_t;

  // Counter must hold 0..limit; a limit of 0 still needs one bit of storage.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction (i_) and data (d_) requesters onto one memory port (m_).
// Latency: zero added; the IDLE winner drives m_ in the same cycle, owner sees m_ responses combinationally.
// Backpressure: m_busy holds ownership until completion; the non-owner sees busy=1 until it is granted.
// Ports: CLK/nRST; i_* and d_* requester buses (addr, wdata, ren, wen, byte_en in;
// rdata, busy, error out); m_* shared memory port; grant_i/grant_d one-hot owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_ren,
  input  logic        i_wen,
  input  logic [3:0]  i_byte_en,
  output logic [31:0] i_rdata,
  output logic        i_busy,
  output logic        i_error,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [3:0]  d_byte_en,
  output logic [31:0] d_rdata,
  output logic        d_busy,
  output logic        d_error,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_ren,
  output logic        m_wen,
  output logic [3:0]  m_byte_en,
  input  logic [31:0] m_rdata,
  input  logic        m_busy,
  input  logic        m_error,
  output logic        grant_i,
  output logic        grant_d
);

  localparam int CW = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t    r_state;
  arb_state_t    w_next;
  logic [CW-1:0] r_starve_cnt;
  logic [CW-1:0] w_starve_nxt;
  bus_req_t      w_i_bus;
  bus_req_t      w_d_bus;
  bus_req_t      w_m_bus;
  logic          w_i_req;
  logic          w_d_req;
  logic          w_own_i;
  logic          w_own_d;

  assign w_i_req = i_ren | i_wen;
  assign w_d_req = d_ren | d_wen;

  assign w_i_bus = '{addr: i_addr, wdata: i_wdata, ren: i_ren, wen: i_wen, byte_en: i_byte_en};
  assign w_d_bus = '{addr: d_addr, wdata: d_wdata, ren: d_ren, wen: d_wen, byte_en: d_byte_en};

  assign m_addr    = w_m_bus.addr;
  assign m_wdata   = w_m_bus.wdata;
  assign m_ren     = w_m_bus.ren;
  assign m_wen     = w_m_bus.wen;
  assign m_byte_en = w_m_bus.byte_en;

  always_comb begin
    w_next       = IDLE;
    w_starve_nxt = r_starve_cnt;
    w_own_i      = 1'b0;
    w_own_d      = 1'b0;
    w_m_bus      = '0;
    i_rdata      = '0;
    i_busy       = 1'b1;
    i_error      = 1'b0;
    d_rdata      = '0;
    d_busy       = 1'b1;
    d_error      = 1'b0;
    grant_i      = 1'b0;
    grant_d      = 1'b0;

    // Owner of the port this cycle. In OWN_x, dropping the strobes leaves
    // no owner, which both aborts the transfer and frees the port.
    case (r_state)
      IDLE: begin
        if (w_i_req && (!w_d_req || r_starve_cnt == LIMIT)) begin
          w_own_i = 1'b1;
        end else if (w_d_req) begin
          w_own_d = 1'b1;
        end
      end
      OWN_I:   w_own_i = w_i_req;
      OWN_D:   w_own_d = w_d_req;
      default: ;
    endcase

    // Reset must silence the port even though IDLE would otherwise arbitrate.
    if (!nRST) begin
      w_own_i = 1'b0;
      w_own_d = 1'b0;
    end

    // Only a stalled transfer keeps ownership; completion or abort re-arbitrates.
    if (w_own_i && m_busy) begin
      w_next = OWN_I;
    end else if (w_own_d && m_busy) begin
      w_next = OWN_D;
    end

    if (w_own_i) begin
      w_m_bus = w_i_bus;
      i_rdata = m_rdata;
      i_busy  = m_busy;
      i_error = m_error;
      grant_i = 1'b1;
    end else if (w_own_d) begin
      w_m_bus = w_d_bus;
      d_rdata = m_rdata;
      d_busy  = m_busy;
      d_error = m_error;
      grant_d = 1'b1;
    end

    // Counts data completions the instruction side has waited through.
    if (!w_i_req || (w_own_i && !m_busy)) begin
      w_starve_nxt = '0;
    end else if (w_own_d && !m_busy && r_starve_cnt != LIMIT) begin
      w_starve_nxt = r_starve_cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_next;
      r_starve_cnt <= w_starve_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// every cycle's port outputs, a negedge monitor compares them.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] i_addr, i_wdata, i_rdata;
  logic        i_ren, i_wen, i_busy, i_error;
  logic [3:0]  i_byte_en;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ren, d_wen, d_busy, d_error;
  logic [3:0]  d_byte_en;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_ren, m_wen, m_busy, m_error;
  logic [3:0]  m_byte_en;
  logic        grant_i, grant_d;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_ren(i_ren), .i_wen(i_wen), .i_byte_en(i_byte_en),
    .i_rdata(i_rdata), .i_busy(i_busy), .i_error(i_error),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ren(d_ren), .d_wen(d_wen), .d_byte_en(d_byte_en),
    .d_rdata(d_rdata), .d_busy(d_busy), .d_error(d_error),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_ren(m_ren), .m_wen(m_wen), .m_byte_en(m_byte_en),
    .m_rdata(m_rdata), .m_busy(m_busy), .m_error(m_error),
    .grant_i(grant_i), .grant_d(grant_d)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] maddr, mwdata, irdata, drdata;
    logic        mren, mwen, gi, gd, ibusy, dbusy, ierr, derr;
    logic [3:0]  mbe;
    int          starve;
  } exp_t;

  exp_t sb[$];
  int   clog[$];       // DUT-observed completions: 1 = instruction, 2 = data
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who holds the port (0 none, 1 I, 2 D) and how many
  // data completions the waiting instruction side has sat through.
  int mdl_owner = 0;
  int mdl_starve = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  exp_t mon_e;
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("m_addr",    m_addr,    mon_e.maddr);
      chk("m_wdata",   m_wdata,   mon_e.mwdata);
      chk("m_ren",     32'(m_ren),     32'(mon_e.mren));
      chk("m_wen",     32'(m_wen),     32'(mon_e.mwen));
      chk("m_byte_en", 32'(m_byte_en), 32'(mon_e.mbe));
      chk("grant_i",   32'(grant_i),   32'(mon_e.gi));
      chk("grant_d",   32'(grant_d),   32'(mon_e.gd));
      chk("i_rdata",   i_rdata,   mon_e.irdata);
      chk("d_rdata",   d_rdata,   mon_e.drdata);
      chk("i_busy",    32'(i_busy),    32'(mon_e.ibusy));
      chk("d_busy",    32'(d_busy),    32'(mon_e.dbusy));
      chk("i_error",   32'(i_error),   32'(mon_e.ierr));
      chk("d_error",   32'(d_error),   32'(mon_e.derr));
      chk("starve_cnt", 32'(int'(dut.r_starve_cnt)), 32'(mon_e.starve));
      if (grant_i && !i_busy) clog.push_back(1);
      if (grant_d && !d_busy) clog.push_back(2);
    end
  end

  // Predict this cycle from the current inputs, queue it, advance the model,
  // then move to just after the next rising edge.
  task automatic step();
    exp_t e;
    bit   ireq, dreq, done;
    int   win;
    ireq = i_ren | i_wen;
    dreq = d_ren | d_wen;
    if (!nRST) win = 0;
    else if (mdl_owner == 1) win = ireq ? 1 : 0;
    else if (mdl_owner == 2) win = dreq ? 2 : 0;
    else if (ireq && (!dreq || mdl_starve >= LIMIT)) win = 1;
    else if (dreq) win = 2;
    else win = 0;

    e.maddr = '0; e.mwdata = '0; e.mren = 0; e.mwen = 0; e.mbe = '0;
    e.gi = 0; e.gd = 0; e.irdata = '0; e.drdata = '0;
    e.ibusy = 1; e.dbusy = 1; e.ierr = 0; e.derr = 0;
    e.starve = nRST ? mdl_starve : 0;
    if (win == 1) begin
      e.maddr = i_addr; e.mwdata = i_wdata; e.mren = i_ren; e.mwen = i_wen; e.mbe = i_byte_en;
      e.gi = 1; e.irdata = m_rdata; e.ibusy = m_busy; e.ierr = m_error;
    end else if (win == 2) begin
      e.maddr = d_addr; e.mwdata = d_wdata; e.mren = d_ren; e.mwen = d_wen; e.mbe = d_byte_en;
      e.gd = 1; e.drdata = m_rdata; e.dbusy = m_busy; e.derr = m_error;
    end
    sb.push_back(e);

    if (!nRST) begin
      mdl_owner  = 0;
      mdl_starve = 0;
    end else begin
      done      = (win != 0) && !m_busy;
      mdl_owner = (win != 0 && m_busy) ? win : 0;
      if (!ireq || (done && win == 1)) mdl_starve = 0;
      else if (done && win == 2 && mdl_starve < LIMIT) mdl_starve++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    i_ren = 0; i_wen = 0; d_ren = 0; d_wen = 0;
    i_addr = '0; i_wdata = 32'h1111_0000; i_byte_en = 4'hF;
    d_addr = '0; d_wdata = 32'h2222_0000; d_byte_en = 4'h3;
    m_busy = 0; m_error = 0; m_rdata = 32'hCAFE_0001;
  endtask

  int exp_seq[6];

  initial begin
    quiet();
    nRST = 1'b0;
    i_ren = 1; d_wen = 1;                 // requests present during reset must be ignored
    @(posedge CLK); #1;
    step(); step();
    nRST = 1'b1;
    quiet(); step();

    // Lone instruction read completes in the same cycle.
    i_ren = 1; i_addr = 32'h8000_0000; step();
    quiet(); step();

    // Data write wins and holds the port through 3 busy cycles; instruction next.
    i_ren = 1; i_addr = 32'h0000_0040; d_wen = 1; d_addr = 32'h0000_1000;
    m_busy = 1; step(); step(); step();
    m_busy = 0; step();
    d_wen = 0; step();

    // Continuous contention with no stalls: 4 data, 1 instruction, data again.
    clog.delete();
    i_ren = 1; d_ren = 1; m_busy = 0;
    repeat (6) step();
    exp_seq = '{2, 2, 2, 2, 1, 2};
    chk("starve_seq_len", 32'(clog.size()), 32'd6);
    for (int k = 0; k < 6 && k < clog.size(); k++)
      chk("starve_seq", 32'(clog[k]), 32'(exp_seq[k]));
    quiet(); step();

    // Abort: instruction stalls, drops its strobe, pending data gets the port.
    i_ren = 1; m_busy = 1; step();
    i_ren = 0; d_ren = 1; step();
    m_busy = 0; step();
    quiet(); step();

    // Error returned to the data owner on completion.
    d_ren = 1; m_busy = 1; step();
    m_busy = 0; m_error = 1; step();
    quiet(); step();

    // Reset in the middle of a stalled data transfer.
    d_wen = 1; i_ren = 1; m_busy = 1; step(); step();
    nRST = 1'b0; step();
    nRST = 1'b1; quiet(); step();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      i_ren = ($urandom_range(0, 3) != 0);
      i_wen = ($urandom_range(0, 7) == 0);
      d_ren = ($urandom_range(0, 2) != 0);
      d_wen = ($urandom_range(0, 5) == 0);
      i_addr = $urandom; i_wdata = $urandom; i_byte_en = 4'($urandom);
      d_addr = $urandom; d_wdata = $urandom; d_byte_en = 4'($urandom);
      m_busy = ($urandom_range(0, 2) == 0);
      m_error = ($urandom_range(0, 9) == 0);
      m_rdata = $urandom;
      nRST = ($urandom_range(0, 99) != 0);
      step();
    end
    nRST = 1'b1; quiet(); step();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
